// File: rtl/bf16_pkg.sv
// bfloat16 field layout, pack/unpack helpers and the operand sequencer state encoding.
package bf16_pkg;

  localparam int BF16_W = 16;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 7;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } bf16_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  function automatic bf16_t bf16_unpack(input logic [BF16_W-1:0] raw);
    bf16_t v;
    v.sign = raw[BF16_W-1];
    v.exp  = raw[BF16_W-2 -: EXP_W];
    v.frac = raw[FRAC_W-1:0];
    return v;
  endfunction

  function automatic logic [BF16_W-1:0] bf16_pack(input bf16_t v);
    return {v.sign, v.exp, v.frac};
  endfunction

endpackage

// File: rtl/bf16_op_sequencer_if.sv
// Compute port between the sequencer (bus side) and a bf16 arithmetic unit (compute side).
interface op_intf;
  import bf16_pkg::*;

  logic              op1_sign;
  logic [EXP_W-1:0]  op1_exp;
  logic [FRAC_W-1:0] op1_frac;
  logic              op2_sign;
  logic [EXP_W-1:0]  op2_exp;
  logic [FRAC_W-1:0] op2_frac;
  logic              op3_sign;
  logic [EXP_W-1:0]  op3_exp;
  logic [FRAC_W-1:0] op3_frac;
  logic              overflow;

  modport bus_side (
    output op1_sign, op1_exp, op1_frac, op2_sign, op2_exp, op2_frac,
    input  op3_sign, op3_exp, op3_frac, overflow
  );

  modport compute_side (
    input  op1_sign, op1_exp, op1_frac, op2_sign, op2_exp, op2_frac,
    output op3_sign, op3_exp, op3_frac, overflow
  );

endinterface

// File: rtl/bf16_op_sequencer.sv
// Feeds bf16 operand pairs to the compute port, captures the result COMP_LATENCY edges after accept.
// Result is held until out_ready; a new pair can be accepted on the same edge the result retires.
module bf16_op_sequencer
  import bf16_pkg::*;
#(
  parameter int COMP_LATENCY = 1,
  parameter int OVF_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BF16_W-1:0]    in_op1,
  input  logic [BF16_W-1:0]    in_op2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BF16_W-1:0]    out_res,
  output logic                 out_ovf,
  input  logic                 clr_ovf_cnt,
  output logic [OVF_CNT_W-1:0] ovf_cnt,
  output logic                 busy,
  op_intf.bus_side             op
);

  localparam int CNT_W = $clog2(COMP_LATENCY + 1);
  localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(COMP_LATENCY - 1);
  localparam logic [OVF_CNT_W-1:0] OVF_MAX  = '1;

  seq_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  bf16_t                op1_q, op1_d;
  bf16_t                op2_q, op2_d;
  bf16_t                res_q, res_d;
  logic                 out_ovf_q, out_ovf_d;
  logic                 out_valid_q, out_valid_d;
  logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic                 accept;
  logic                 capture;

  // Gated by rst_n so nothing is taken while reset is held.
  assign in_ready = rst_n & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    res_d       = res_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    ovf_cnt_d   = ovf_cnt_q;
    capture     = 1'b0;

    case (state_q)
      IDLE: begin
      end
      WAIT: begin
        if (cnt_q == '0) begin
          capture     = 1'b1;
          res_d       = {op.op3_sign, op.op3_exp, op.op3_frac};
          out_ovf_d   = op.overflow;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Overrides the DONE->IDLE retire so a waiting pair is taken on the same edge.
    if (accept) begin
      op1_d   = bf16_unpack(in_op1);
      op2_d   = bf16_unpack(in_op2);
      cnt_d   = CNT_LOAD;
      state_d = WAIT;
    end

    if (clr_ovf_cnt) begin
      ovf_cnt_d = '0;
    end else if (capture && op.overflow && (ovf_cnt_q != OVF_MAX)) begin
      ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      res_q       <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      ovf_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      res_q       <= res_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  assign op.op1_sign = op1_q.sign;
  assign op.op1_exp  = op1_q.exp;
  assign op.op1_frac = op1_q.frac;
  assign op.op2_sign = op2_q.sign;
  assign op.op2_exp  = op2_q.exp;
  assign op.op2_frac = op2_q.frac;

  assign out_res   = bf16_pack(res_q);
  assign out_ovf   = out_ovf_q;
  assign out_valid = out_valid_q;
  assign ovf_cnt   = ovf_cnt_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bf16_op_sequencer.sv
// Bench for bf16_op_sequencer: three instances (latency 3, 1, 4) each with a stub compute model.
module tb_bf16_op_sequencer;
  import bf16_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] rst_n, in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [N-1:0] clr_ovf_cnt, busy, stub_ovf, stub_xor;
  logic [15:0]  in_op1 [N];
  logic [15:0]  in_op2 [N];
  logic [15:0]  out_res [N];
  logic [15:0]  stub_op3 [N];
  logic [15:0]  obs_op1 [N];
  logic [15:0]  obs_op2 [N];
  logic [7:0]   ovf_cnt [N];

  int checks = 0;
  int errors = 0;
  logic [16:0] sb_q[$];

  for (genvar g = 0; g < N; g++) begin : g_inst
    op_intf opi();
    logic [15:0] op3_w;

    assign obs_op1[g] = {opi.op1_sign, opi.op1_exp, opi.op1_frac};
    assign obs_op2[g] = {opi.op2_sign, opi.op2_exp, opi.op2_frac};
    // Stub compute: either a fixed result or op1^op2 of the presented operands.
    assign op3_w = stub_xor[g] ? (obs_op1[g] ^ obs_op2[g]) : stub_op3[g];
    assign {opi.op3_sign, opi.op3_exp, opi.op3_frac} = op3_w;
    assign opi.overflow = stub_ovf[g];

    bf16_op_sequencer #(
      .COMP_LATENCY(g == 0 ? 3 : (g == 1 ? 1 : 4)),
      .OVF_CNT_W   (8)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_op1     (in_op1[g]),
      .in_op2     (in_op2[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .out_res    (out_res[g]),
      .out_ovf    (out_ovf[g]),
      .clr_ovf_cnt(clr_ovf_cnt[g]),
      .ovf_cnt    (ovf_cnt[g]),
      .busy       (busy[g]),
      .op         (opi.bus_side)
    );
  end

  function automatic int lat(input int i);
    return (i == 0) ? 3 : ((i == 1) ? 1 : 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Samples handshakes just before the next edge; scoreboard push on accept, pop on transfer.
  task automatic sample(input int i, output bit acc, output bit xfer);
    logic [16:0] e;
    #1;
    acc  = in_valid[i] & in_ready[i];
    xfer = out_valid[i] & out_ready[i];
    if (xfer) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected inst %0d got %h ovf %b, none queued", i, out_res[i], out_ovf[i]);
      end else begin
        e = sb_q.pop_front();
        if ({out_ovf[i], out_res[i]} !== e) begin
          errors++;
          $display("FAIL result inst %0d got ovf=%b res=%h exp ovf=%b res=%h",
                   i, out_ovf[i], out_res[i], e[16], e[15:0]);
        end
      end
    end
    if (acc) sb_q.push_back({stub_ovf[i], stub_xor[i] ? (in_op1[i] ^ in_op2[i]) : stub_op3[i]});
  endtask

  task automatic test_reset();
    rst_n = '0; in_valid = '1; out_ready = '0;
    tick(); tick();
    for (int i = 0; i < N; i++) begin
      checks += 5;
      if (in_ready[i] !== 1'b0)    begin errors++; $display("FAIL rst_in_ready inst %0d got %b exp 0", i, in_ready[i]); end
      if (out_valid[i] !== 1'b0)   begin errors++; $display("FAIL rst_out_valid inst %0d got %b exp 0", i, out_valid[i]); end
      if (obs_op1[i][14:7] !== 8'h00) begin errors++; $display("FAIL rst_op1_exp inst %0d got %h exp 00", i, obs_op1[i][14:7]); end
      if (ovf_cnt[i] !== 8'd0)     begin errors++; $display("FAIL rst_ovf_cnt inst %0d got %0d exp 0", i, ovf_cnt[i]); end
      if (out_res[i] !== 16'h0)    begin errors++; $display("FAIL rst_out_res inst %0d got %h exp 0000", i, out_res[i]); end
    end
    in_valid = '0; rst_n = '1;
    tick();
    for (int i = 0; i < N; i++) begin
      checks += 2;
      if (in_ready[i] !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready inst %0d got %b exp 1", i, in_ready[i]); end
      if (busy[i] !== 1'b0)     begin errors++; $display("FAIL post_rst_busy inst %0d got %b exp 0", i, busy[i]); end
    end
  endtask

  task automatic test_single();
    bit a, x;
    stub_xor[0] = 1'b0; stub_op3[0] = 16'h4040; stub_ovf[0] = 1'b0;
    in_op1[0] = 16'h3F80; in_op2[0] = 16'h4000; in_valid[0] = 1'b1; out_ready[0] = 1'b0;
    sample(0, a, x);
    checks++;
    if (a !== 1'b1) begin errors++; $display("FAIL single_accept got %b exp 1", a); end
    tick();
    in_valid[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks += 3;
      if (obs_op1[0] !== 16'h3F80) begin errors++; $display("FAIL single_op1 edge+%0d got %h exp 3f80 (exp 7f)", k, obs_op1[0]); end
      if (obs_op2[0] !== 16'h4000) begin errors++; $display("FAIL single_op2 edge+%0d got %h exp 4000 (exp 80)", k, obs_op2[0]); end
      if (out_valid[0] !== 1'b0)   begin errors++; $display("FAIL single_early_valid edge+%0d got %b exp 0", k, out_valid[0]); end
      tick();
    end
    checks += 3;
    if (out_valid[0] !== 1'b1)   begin errors++; $display("FAIL single_valid got %b exp 1", out_valid[0]); end
    if (out_res[0] !== 16'h4040) begin errors++; $display("FAIL single_res got %h exp 4040", out_res[0]); end
    if (out_ovf[0] !== 1'b0)     begin errors++; $display("FAIL single_ovf got %b exp 0", out_ovf[0]); end
  endtask

  task automatic test_backpressure();
    bit a, x;
    stub_op3[0] = 16'h7F80;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks += 3;
      if (out_valid[0] !== 1'b1)   begin errors++; $display("FAIL bp_valid cyc %0d got %b exp 1", k, out_valid[0]); end
      if (out_res[0] !== 16'h4040) begin errors++; $display("FAIL bp_res cyc %0d got %h exp 4040", k, out_res[0]); end
      if (in_ready[0] !== 1'b0)    begin errors++; $display("FAIL bp_in_ready cyc %0d got %b exp 0", k, in_ready[0]); end
    end
    out_ready[0] = 1'b1;
    sample(0, a, x);
    checks++;
    if (x !== 1'b1) begin errors++; $display("FAIL bp_transfer got %b exp 1", x); end
    tick();
    checks += 2;
    if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL bp_after_valid got %b exp 0", out_valid[0]); end
    if (busy[0] !== 1'b0)      begin errors++; $display("FAIL bp_after_busy got %b exp 0", busy[0]); end
  endtask

  // Streams n random pairs with out_ready held high; checks spacing, same-edge accept and ovf_cnt.
  task automatic run_stream(input int i, input int n);
    int n_acc = 0, n_x = 0, cyc = 0, last = -1, exp_cnt;
    bit a, x;
    in_op1[i] = 16'($urandom); in_op2[i] = 16'($urandom);
    in_valid[i] = 1'b1; out_ready[i] = 1'b1;
    while (n_x < n && cyc < 4000) begin
      sample(i, a, x);
      if (x) begin
        n_x++;
        if (last >= 0) begin
          checks++;
          if (cyc - last != lat(i) + 1) begin errors++; $display("FAIL stream_gap inst %0d got %0d exp %0d", i, cyc - last, lat(i) + 1); end
        end
        last = cyc;
        if (n_acc < n) begin
          checks++;
          if (!a) begin errors++; $display("FAIL same_edge_accept inst %0d xfer %0d got 0 exp 1", i, n_x); end
        end
        if (stub_ovf[i] && (n_x == 100 || n_x == 255 || n_x == 256 || n_x == 300)) begin
          exp_cnt = (n_x > 255) ? 255 : n_x;
          checks++;
          if (ovf_cnt[i] !== 8'(exp_cnt)) begin errors++; $display("FAIL ovf_cnt xfer %0d got %0d exp %0d", n_x, ovf_cnt[i], exp_cnt); end
        end
      end
      tick();
      cyc++;
      if (a) begin
        n_acc++;
        if (n_acc < n) begin in_op1[i] = 16'($urandom); in_op2[i] = 16'($urandom); end
        else in_valid[i] = 1'b0;
      end
    end
    checks++;
    if (n_x != n) begin errors++; $display("FAIL stream_timeout inst %0d got %0d results exp %0d", i, n_x, n); end
  endtask

  task automatic test_back_to_back();
    stub_xor[1] = 1'b1; stub_ovf[1] = 1'b0;
    run_stream(1, 4);
  endtask

  task automatic test_ovf_cnt();
    bit a, x;
    stub_xor[1] = 1'b1; stub_ovf[1] = 1'b1;
    run_stream(1, 300);
    // One more op with clear asserted exactly on its capture edge.
    in_valid[1] = 1'b1; out_ready[1] = 1'b0;
    sample(1, a, x);
    tick();
    in_valid[1] = 1'b0; clr_ovf_cnt[1] = 1'b1;
    tick();
    clr_ovf_cnt[1] = 1'b0;
    checks += 2;
    if (out_valid[1] !== 1'b1) begin errors++; $display("FAIL clr_capture_valid got %b exp 1", out_valid[1]); end
    if (ovf_cnt[1] !== 8'd0)   begin errors++; $display("FAIL clr_ovf_cnt got %0d exp 0", ovf_cnt[1]); end
    out_ready[1] = 1'b1;
    sample(1, a, x);
    tick();
    checks++;
    if (ovf_cnt[1] !== 8'd0) begin errors++; $display("FAIL clr_hold got %0d exp 0", ovf_cnt[1]); end
  endtask

  task automatic test_reset_mid_wait();
    bit a, x;
    stub_xor[2] = 1'b1; stub_ovf[2] = 1'b0;
    in_op1[2] = 16'h1234; in_op2[2] = 16'h0F0F; in_valid[2] = 1'b1; out_ready[2] = 1'b1;
    sample(2, a, x);
    tick();
    in_valid[2] = 1'b0; rst_n[2] = 1'b0;
    tick();
    sb_q.delete();
    checks += 2;
    if (busy[2] !== 1'b0)     begin errors++; $display("FAIL midrst_busy got %b exp 0", busy[2]); end
    if (in_ready[2] !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got %b exp 0", in_ready[2]); end
    rst_n[2] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (out_valid[2] !== 1'b0) begin errors++; $display("FAIL midrst_valid cyc %0d got %b exp 0", k, out_valid[2]); end
      tick();
    end
    run_stream(2, 2);
  endtask

  initial begin
    stub_ovf = '0; stub_xor = '0; clr_ovf_cnt = '0;
    for (int i = 0; i < N; i++) begin
      in_op1[i] = '0; in_op2[i] = '0; stub_op3[i] = '0;
    end
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_ovf_cnt();
    test_reset_mid_wait();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d entries exp 0", sb_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
